// File: rtl/brisc_io_pkg.sv
// Shared definitions for the BRISC I/O reporting blocks: serializer and
// sequencer state encodings, ASCII constants and the hex/frame byte helpers.
package brisc_io_pkg;

    // Serial line states of the 8N1 byte serializer.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Frame sequencer states: waiting for a trigger, handing bytes to the
    // serializer, and waiting for the final stop bit to finish.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_SEND = 2'd1,
        SEQ_LAST = 2'd2
    } seq_state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // Index of the last byte of a frame (4 hex digits, CR, LF).
    localparam logic [2:0] FRAME_LAST_IDX = 3'd5;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) begin
            r = ASCII_0 + {4'h0, n};
        end else begin
            r = ASCII_A + {4'h0, n} - 8'd10;
        end
        return r;
    endfunction

    // Byte idx of the frame reporting value v: MSB nibble first, then CR LF.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [15:0] v);
        logic [7:0] r;
        case (idx)
            3'd0:    r = nibble_to_ascii(v[15:12]);
            3'd1:    r = nibble_to_ascii(v[11:8]);
            3'd2:    r = nibble_to_ascii(v[7:4]);
            3'd3:    r = nibble_to_ascii(v[3:0]);
            3'd4:    r = ASCII_CR;
            3'd5:    r = ASCII_LF;
            default: r = ASCII_LF;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/port_uart_tx_if.sv
// Bundle of the monitored port value, resend request and UART reporting
// outputs. The master side drives the port, the slave side is the reporter.
interface port_uart_tx_if;
    logic [15:0] port_val;
    logic        send_req;
    logic        tx;
    logic        busy;
    logic [7:0]  frames_sent;

    modport master (
        output port_val,
        output send_req,
        input  tx,
        input  busy,
        input  frames_sent
    );

    modport slave (
        input  port_val,
        input  send_req,
        output tx,
        output busy,
        output frames_sent
    );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 serializer: one start bit, 8 data bits LSB first, one stop bit.
// ready is high while idle and also in the last cycle of the stop bit, so a
// byte offered then starts its start bit with no idle gap. CLKS_PER_BIT >= 2.
module uart_tx_byte
    import brisc_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    // State registers with synchronous reset to an idle-high line.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Bit timer, bit sequencing and the next value of the serial line.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        ready   = 1'b0;
        bit_end = (cnt_q == CNT_LAST);
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (valid) begin
                    shift_d = data;
                    tx_d    = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    bit_d   = 3'd0;
                    state_d = ST_START;
                end else begin
                    tx_d = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = {CNT_W{1'b0}};
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b1, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    ready = 1'b1;
                    cnt_d = {CNT_W{1'b0}};
                    bit_d = 3'd0;
                    if (valid) begin
                        shift_d = data;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                bit_d   = 3'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx = tx_q;

endmodule

// File: rtl/port_uart_tx.sv
// Reports a 16-bit output port over UART as "HHHH\r\n" whenever the value
// differs from the last one reported, or on request. Values that change while
// a frame is in flight coalesce: only the newest is reported afterwards.
module port_uart_tx
    import brisc_io_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic          CLK,
    input  logic          RST,
    port_uart_tx_if.slave bus
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

    seq_state_t  seq_q, seq_d;
    logic [15:0] snap_q, snap_d;
    logic [15:0] last_sent_q, last_sent_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic        busy_q, busy_d;
    logic [7:0]  frames_q, frames_d;

    logic        trigger;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        ser_tx;

    // Sequencer, snapshot and frame counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            seq_q       <= SEQ_IDLE;
            snap_q      <= 16'h0000;
            last_sent_q <= 16'h0000;
            byte_idx_q  <= 3'd0;
            busy_q      <= 1'b0;
            frames_q    <= 8'd0;
        end else begin
            seq_q       <= seq_d;
            snap_q      <= snap_d;
            last_sent_q <= last_sent_d;
            byte_idx_q  <= byte_idx_d;
            busy_q      <= busy_d;
            frames_q    <= frames_d;
        end
    end

    // Change detect in idle, then feed the six frame bytes back-to-back and
    // close the frame when the serializer finishes the last stop bit.
    always_comb begin
        seq_d       = seq_q;
        snap_d      = snap_q;
        last_sent_d = last_sent_q;
        byte_idx_d  = byte_idx_q;
        busy_d      = busy_q;
        frames_d    = frames_q;
        byte_valid  = 1'b0;
        byte_data   = frame_byte(byte_idx_q, snap_q);
        trigger     = (bus.port_val != last_sent_q) || bus.send_req;
        case (seq_q)
            SEQ_IDLE: begin
                if (trigger) begin
                    snap_d      = bus.port_val;
                    last_sent_d = bus.port_val;
                    byte_idx_d  = 3'd0;
                    busy_d      = 1'b1;
                    seq_d       = SEQ_SEND;
                end else begin
                    busy_d = 1'b0;
                end
            end
            SEQ_SEND: begin
                byte_valid = 1'b1;
                if (byte_ready) begin
                    if (byte_idx_q == FRAME_LAST_IDX) begin
                        seq_d = SEQ_LAST;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end else begin
                    seq_d = SEQ_SEND;
                end
            end
            SEQ_LAST: begin
                // Serializer is busy with the LF; its ready marks the stop bit end.
                if (byte_ready) begin
                    busy_d     = 1'b0;
                    frames_d   = frames_q + 8'd1;
                    byte_idx_d = 3'd0;
                    seq_d      = SEQ_IDLE;
                end else begin
                    seq_d = SEQ_LAST;
                end
            end
            default: begin
                seq_d      = SEQ_IDLE;
                busy_d     = 1'b0;
                byte_idx_d = 3'd0;
            end
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .CLK   (CLK),
        .RST   (RST),
        .data  (byte_data),
        .valid (byte_valid),
        .ready (byte_ready),
        .tx    (ser_tx)
    );

    assign bus.tx          = ser_tx;
    assign bus.busy        = busy_q;
    assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_port_uart_tx.sv
// Bench for port_uart_tx at 4 clocks per bit. A UART receiver decodes tx and
// compares each byte against a scoreboard filled when stimulus is applied.
module tb_port_uart_tx;

    localparam int CPB = 4;
    localparam int FRAME_BUSY = 60 * CPB + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    port_uart_tx_if bus ();

    port_uart_tx #(
        .CLK_HZ (1000000),
        .BAUD   (250000)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    bit         mon_en = 1'b1;
    int         busy_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected frame bytes for value v, from an independent hex table.
    task automatic push_frame(input logic [15:0] v);
        string      hx;
        logic [3:0] nib;
        hx = "0123456789ABCDEF";
        for (int i = 0; i < 4; i++) begin
            nib = v[15 - 4 * i -: 4];
            sb.push_back(hx[int'(nib)]);
        end
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cyc++;
        end
    endtask

    task automatic pulse_req();
        bus.send_req = 1'b1;
        @(negedge clk);
        if (bus.busy === 1'b1) busy_cyc++;
        bus.send_req = 1'b0;
    endtask

    // Wait for busy, check the one-cycle start-bit latency.
    task automatic frame_start(input string tag, input int exp_wait);
        int n;
        n = 0;
        while (bus.busy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_wait"}, n, exp_wait);
        check({tag, "_pre_tx"}, {31'd0, bus.tx}, 32'd1);
        @(negedge clk);
        check({tag, "_start_bit"}, {31'd0, bus.tx}, 32'd0);
        busy_cyc = 2;
    endtask

    // Wait for busy to drop and check frame length and count.
    task automatic frame_end(input string tag, input logic [7:0] exp_cnt);
        int g;
        g = 0;
        while (g < 1000) begin
            @(negedge clk);
            g++;
            if (bus.busy !== 1'b1) break;
            busy_cyc++;
        end
        check({tag, "_len"}, busy_cyc, FRAME_BUSY);
        check({tag, "_cnt"}, {24'd0, bus.frames_sent}, {24'd0, exp_cnt});
        check({tag, "_tx_idle"}, {31'd0, bus.tx}, 32'd1);
    endtask

    // UART receiver: sample each bit in its second clock.
    initial begin : monitor
        int         cnt;
        bit         active;
        logic [7:0] b;
        cnt = 0;
        active = 1'b0;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                active = 1'b0;
            end else if (!active) begin
                if (bus.tx === 1'b0) begin
                    active = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if (cnt >= CPB + 1 && cnt <= 8 * CPB + 1 && ((cnt - 1) % CPB) == 0) begin
                    b[3'((cnt - 1) / CPB - 1)] = bus.tx;
                end else if (cnt == 9 * CPB + 1) begin
                    active = 1'b0;
                    if (mon_en) begin
                        check("stop_bit", {31'd0, bus.tx}, 32'd1);
                        if (sb.size() == 0) check("extra_byte", {24'd0, b}, 32'h100);
                        else check("byte", {24'd0, b}, {24'd0, sb.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : main
        int bad;
        int seen;
        rst = 1'b1;
        bus.port_val = 16'h0000;
        bus.send_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, bus.tx}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_cnt", {24'd0, bus.frames_sent}, 32'd0);
        rst = 1'b0;

        // 1: idle after reset, no frame for an unchanged zero port
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
        end
        check("t1_idle", bad, 32'd0);
        check("t1_cnt", {24'd0, bus.frames_sent}, 32'd0);

        // 2: single frame "BEEF"
        repeat (10) @(negedge clk);
        bus.port_val = 16'hBEEF;
        push_frame(16'hBEEF);
        frame_start("t2", 1);
        frame_end("t2", 8'd1);
        check("t2_sb", sb.size(), 32'd0);

        // 3: changes during a frame coalesce to the newest value
        bus.port_val = 16'h00A5;
        push_frame(16'h00A5);
        frame_start("t3a", 1);
        tick(3);
        bus.port_val = 16'h1234;
        tick(20);
        bus.port_val = 16'h5678;
        push_frame(16'h5678);
        frame_end("t3a", 8'd2);
        frame_start("t3b", 1);
        frame_end("t3b", 8'd3);
        check("t3_sb", sb.size(), 32'd0);

        // 4: resend on request; request while busy and a bounced value ignored
        push_frame(16'h5678);
        pulse_req();
        frame_start("t4", 0);
        tick(30);
        pulse_req();
        bus.port_val = 16'h0000;
        tick(10);
        bus.port_val = 16'h5678;
        frame_end("t4", 8'd4);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.busy === 1'b1) seen++;
        end
        check("t4_no_queue", seen, 32'd0);
        check("t4_cnt", {24'd0, bus.frames_sent}, 32'd4);
        check("t4_sb", sb.size(), 32'd0);

        // 5: reset mid-frame aborts it; the held port value is resent afterwards
        mon_en = 1'b0;
        pulse_req();
        tick(100);
        check("t5_mid_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_tx", {31'd0, bus.tx}, 32'd1);
        check("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("t5_rst_cnt", {24'd0, bus.frames_sent}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        push_frame(16'h5678);
        frame_start("t5", 1);
        frame_end("t5", 8'd1);
        check("t5_sb", sb.size(), 32'd0);

        // 6: frame counter reaches 255 and wraps to 0
        for (int i = 0; i < 254; i++) begin
            push_frame(16'h5678);
            pulse_req();
            frame_start("t6", 0);
            frame_end("t6", 8'(i + 2));
        end
        check("t6_at_255", {24'd0, bus.frames_sent}, 32'd255);
        push_frame(16'h5678);
        pulse_req();
        frame_start("t6_wrap", 0);
        frame_end("t6_wrap", 8'd0);
        repeat (5) @(negedge clk);
        check("t6_sb", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
